// File: rtl/alu_pkg.sv
// Shared encodings for the ALU front end: op codes, FSM states, request payload.
package alu_pkg;

    localparam int unsigned DATA_W = 3;
    localparam int unsigned OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } arb_state_e;

    typedef struct packed {
        alu_op_e           op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              id;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 3-bit ALU datapath. M_1/M_0 select add, sub, AND, XOR.
// In sub mode c_in acts as an active-low borrow-in, so c_in=0 yields a-b
// with c_out=1 meaning no borrow. In logic modes c_out reports the
// carry-generate term, which callers mask if they want a clean flag.
module ALU
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic              M_1,
    input  logic              M_0,
    input  logic              c_in,
    output logic [DATA_W-1:0] out,
    output logic              c_out
);

    // Combinational datapath selected by the mode pins.
    always_comb begin
        out   = '0;
        c_out = 1'b0;
        unique case ({M_1, M_0})
            2'b00: {c_out, out} = {1'b0, in_0} + {1'b0, in_1} + {3'b000, c_in};
            2'b01: {c_out, out} = {1'b0, in_0} + {1'b0, ~in_1} + {3'b000, ~c_in};
            2'b10: begin
                out   = in_0 & in_1;
                c_out = |(in_0 & in_1);
            end
            default: begin
                out   = in_0 ^ in_1;
                c_out = |(in_0 & in_1);
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared ALU. Accepts one
// request, runs it through the ALU from registered operands, and holds a
// tagged result until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [OP_W-1:0]   req_op_0,
    input  logic [OP_W-1:0]   req_op_1,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [DATA_W-1:0] req_b_1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_out,
    output logic              res_c_out,
    output logic              res_id,
    output logic [CNT_W-1:0]  op_count
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic              last;
    alu_req_t          req_r;
    logic              grant_vld_c;
    logic              grant_c;
    logic              accept_c;
    logic              capture_c;
    logic              consume_c;
    logic [OP_W-1:0]   op_bits_c;
    logic [DATA_W-1:0] alu_out;
    logic              alu_c_out;
    logic              logic_op_c;

    assign op_bits_c  = req_r.op;
    assign logic_op_c = (req_r.op == OP_AND) || (req_r.op == OP_XOR);

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_vld_c = req_valid_0 | req_valid_1;
        grant_c     = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant_c = ~last;
        end else if (req_valid_1) begin
            grant_c = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, request readies and datapath strobes.
    always_comb begin
        state_nxt   = state;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        consume_c   = 1'b0;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_0 = !rst && grant_vld_c && !grant_c;
                req_ready_1 = !rst && grant_vld_c && grant_c;
                if (grant_vld_c) begin
                    accept_c  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture_c = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    consume_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, tie-break history, result registers and consumed-op counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            req_r     <= '0;
            res_valid <= 1'b0;
            res_out   <= '0;
            res_c_out <= 1'b0;
            res_id    <= 1'b0;
            op_count  <= '0;
        end else begin
            if (accept_c) begin
                req_r.op <= alu_op_e'(grant_c ? req_op_1 : req_op_0);
                req_r.a  <= grant_c ? req_a_1 : req_a_0;
                req_r.b  <= grant_c ? req_b_1 : req_b_0;
                req_r.id <= grant_c;
                last     <= grant_c;
            end
            if (capture_c) begin
                res_valid <= 1'b1;
                res_out   <= alu_out;
                res_c_out <= logic_op_c ? 1'b0 : alu_c_out;
                res_id    <= req_r.id;
            end
            if (consume_c) begin
                res_valid <= 1'b0;
                op_count  <= op_count + CNT_W'(1);
            end
        end
    end

    ALU u_alu (
        .in_0  (req_r.a),
        .in_1  (req_r.b),
        .M_1   (op_bits_c[1]),
        .M_0   (op_bits_c[0]),
        .c_in  (1'b0),
        .out   (alu_out),
        .c_out (alu_c_out)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with hand-computed expected results.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       req_valid_0;
    logic       req_valid_1;
    logic       req_ready_0;
    logic       req_ready_1;
    logic [1:0] req_op_0;
    logic [1:0] req_op_1;
    logic [2:0] req_a_0;
    logic [2:0] req_a_1;
    logic [2:0] req_b_0;
    logic [2:0] req_b_1;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_out;
    logic       res_c_out;
    logic       res_id;
    logic [7:0] op_count;

    int n_tests;
    int n_fail;
    int exp_count;

    alu_arbiter #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_0 (req_valid_0),
        .req_valid_1 (req_valid_1),
        .req_ready_0 (req_ready_0),
        .req_ready_1 (req_ready_1),
        .req_op_0    (req_op_0),
        .req_op_1    (req_op_1),
        .req_a_0     (req_a_0),
        .req_a_1     (req_a_1),
        .req_b_0     (req_b_0),
        .req_b_1     (req_b_1),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_out     (res_out),
        .res_c_out   (res_c_out),
        .res_id      (res_id),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        if (id) begin
            req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b;
        end else begin
            req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b;
        end
    endtask

    // One complete transaction from an idle arbiter with a single requester.
    task automatic do_op(input logic id, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] exp_out, input logic exp_c);
        set_req(id, op, a, b);
        #1;
        check("ready_winner", 32'(id ? req_ready_1 : req_ready_0), 1);
        check("ready_loser", 32'(id ? req_ready_0 : req_ready_1), 0);
        tick();
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        check("exec_res_valid", 32'(res_valid), 0);
        tick();
        check("hold_res_valid", 32'(res_valid), 1);
        check("res_out", 32'(res_out), 32'(exp_out));
        check("res_c_out", 32'(res_c_out), 32'(exp_c));
        check("res_id", 32'(res_id), 32'(id));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_count++;
        check("consumed_res_valid", 32'(res_valid), 0);
        check("op_count", 32'(op_count), 32'(exp_count & 255));
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        exp_count = 0;
        rst = 1'b1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        req_op_0 = 2'b00; req_op_1 = 2'b00;
        req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
        res_ready = 1'b0;

        // Reset values, with both valids high to show readies stay low.
        #1;
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_out", 32'(res_out), 0);
        check("rst_res_c_out", 32'(res_c_out), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_ready_0", 32'(req_ready_0), 0);
        check("rst_ready_1", 32'(req_ready_1), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("first_tie_ready_0", 32'(req_ready_0), 1);
        check("first_tie_ready_1", 32'(req_ready_1), 0);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        tick();

        // Arithmetic and logic ops; AND follows an add with carry out.
        do_op(1'b0, 2'b00, 3'd5, 3'd6, 3'd3, 1'b1);
        do_op(1'b1, 2'b01, 3'd2, 3'd5, 3'd5, 1'b0);
        do_op(1'b1, 2'b01, 3'd6, 3'd6, 3'd0, 1'b1);
        do_op(1'b0, 2'b00, 3'd7, 3'd1, 3'd0, 1'b1);
        do_op(1'b1, 2'b10, 3'b110, 3'b011, 3'b010, 1'b0);
        do_op(1'b1, 2'b11, 3'b110, 3'b011, 3'b101, 1'b0);

        // Continuous contention: grants alternate, one accept every 3 cycles.
        res_ready = 1'b1;
        set_req(1'b0, 2'b00, 3'd1, 3'd2);
        set_req(1'b1, 2'b01, 3'd7, 3'd3);
        #1;
        for (int i = 0; i < 6; i++) begin
            check("cont_ready_0", 32'(req_ready_0), ((i % 2) == 0) ? 1 : 0);
            check("cont_ready_1", 32'(req_ready_1), ((i % 2) == 1) ? 1 : 0);
            tick();
            check("cont_exec_ready_0", 32'(req_ready_0), 0);
            check("cont_exec_ready_1", 32'(req_ready_1), 0);
            tick();
            check("cont_res_id", 32'(res_id), i % 2);
            check("cont_res_out", 32'(res_out), ((i % 2) == 0) ? 3 : 4);
            check("cont_res_c_out", 32'(res_c_out), ((i % 2) == 0) ? 0 : 1);
            check("cont_hold_ready_1", 32'(req_ready_1), 0);
            tick();
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        res_ready = 1'b0;
        exp_count += 6;
        check("cont_op_count", 32'(op_count), 32'(exp_count));

        // Backpressure in HOLD for 10 cycles with both requesters waiting.
        set_req(1'b0, 2'b00, 3'd3, 3'd3);
        #1;
        tick();
        req_valid_0 = 1'b0;
        tick();
        set_req(1'b0, 2'b00, 3'd3, 3'd3);
        set_req(1'b1, 2'b01, 3'd5, 3'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_res_valid", 32'(res_valid), 1);
            check("bp_res_out", 32'(res_out), 6);
            check("bp_ready_0", 32'(req_ready_0), 0);
            check("bp_ready_1", 32'(req_ready_1), 0);
            check("bp_op_count", 32'(op_count), 32'(exp_count));
            tick();
        end
        res_ready = 1'b1;
        tick();
        exp_count++;
        check("bp_consumed_op_count", 32'(op_count), 32'(exp_count));
        check("bp_consumed_res_valid", 32'(res_valid), 0);
        check("bp_next_ready_1", 32'(req_ready_1), 1);
        check("bp_next_ready_0", 32'(req_ready_0), 0);
        tick();
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        check("bp_next_exec_ready_1", 32'(req_ready_1), 0);
        tick();
        check("bp_next_res_id", 32'(res_id), 1);
        check("bp_next_res_out", 32'(res_out), 4);
        check("bp_next_res_c_out", 32'(res_c_out), 1);
        tick();
        res_ready = 1'b0;
        exp_count++;
        check("bp_next_op_count", 32'(op_count), 32'(exp_count));

        // Reset while in EXEC.
        set_req(1'b0, 2'b00, 3'd5, 3'd6);
        #1;
        tick();
        req_valid_0 = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_exec_res_out", 32'(res_out), 0);
        check("abort_exec_res_c_out", 32'(res_c_out), 0);
        check("abort_exec_res_id", 32'(res_id), 0);
        check("abort_exec_op_count", 32'(op_count), 0);
        tick();
        rst = 1'b0;
        exp_count = 0;
        tick();
        check("abort_exec_res_valid", 32'(res_valid), 0);

        // Reset while in HOLD.
        set_req(1'b1, 2'b00, 3'd5, 3'd6);
        #1;
        tick();
        req_valid_1 = 1'b0;
        tick();
        check("pre_abort_hold_res_valid", 32'(res_valid), 1);
        check("pre_abort_hold_res_id", 32'(res_id), 1);
        rst = 1'b1;
        #1;
        check("abort_hold_res_valid", 32'(res_valid), 0);
        check("abort_hold_res_out", 32'(res_out), 0);
        check("abort_hold_res_c_out", 32'(res_c_out), 0);
        check("abort_hold_res_id", 32'(res_id), 0);
        check("abort_hold_op_count", 32'(op_count), 0);
        set_req(1'b0, 2'b00, 3'd1, 3'd1);
        set_req(1'b1, 2'b00, 3'd2, 3'd2);
        #1;
        check("abort_rst_ready_0", 32'(req_ready_0), 0);
        check("abort_rst_ready_1", 32'(req_ready_1), 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_tie_ready_0", 32'(req_ready_0), 1);
        check("post_rst_tie_ready_1", 32'(req_ready_1), 0);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        tick();
        do_op(1'b0, 2'b00, 3'd1, 3'd1, 3'd2, 1'b0);

        // Counter wrap: 255 then 0 after 256 consumed ops in total.
        set_req(1'b0, 2'b00, 3'd1, 3'd1);
        res_ready = 1'b1;
        repeat (254 * 3) tick();
        check("wrap_op_count_255", 32'(op_count), 255);
        repeat (3) tick();
        check("wrap_op_count_0", 32'(op_count), 0);
        req_valid_0 = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared 3-bit `ALU` datapath. It accepts operation requests over valid/ready handshakes and arbitrates round-robin between requester 0 and requester 1. It drives the single `ALU` instance from registered operands and returns a registered, tagged result over a valid/ready result channel. It sits between the control logic and the ALU, so the ALU needs no awareness of who issued an operation.

## Interface
Parameters:
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_0 / req_valid_1  in  1  request pending from requester 0 / 1.
- req_ready_0 / req_ready_1  out  1  request accepted when valid and ready are both high at a clk edge.
- req_op_0 / req_op_1  in  2  00 add, 01 sub, 10 AND, 11 XOR; bit 1 maps to M_1 and bit 0 to M_0.
- req_a_0 / req_a_1, req_b_0 / req_b_1  in  3  operands in_0 and in_1.
- res_valid  out  1  result held and available.
- res_ready  in  1  consumer accepts the result.
- res_out  out  3  result value.
- res_c_out  out  1  carry/no-borrow flag.
- res_id  out  1  requester that issued the op.
- op_count  out  CNT_W  number of results consumed; wraps from 2^CNT_W-1 to 0.

## Operation
- States: IDLE, EXEC, HOLD.
- IDLE grant:
  - If only one valid is high, that requester is granted.
  - If both are high, the requester other than `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- req_ready_x = (state==IDLE) && grant==x; the function is purely combinational in valid and state. At most one ready is high per cycle.
- Accept (IDLE):
  - Latch op, a, b and id.
  - Set `last` to id.
  - Go to EXEC.
- EXEC:
  - The ALU sees the latched operands.
  - At the next edge, capture out, c_out and id into the result registers.
  - Go to HOLD.
- HOLD:
  - res_valid=1.
  - On res_valid && res_ready: increment op_count, go to IDLE.
- Arithmetic:
  - add: {res_c_out,res_out} = a+b (4-bit sum).
  - sub: res_out = (a−b) mod 8; res_c_out=1 iff a≥b (no borrow).
  - AND / XOR: bitwise; res_c_out forced to 0 by this block, whatever the ALU carry holds.
- Requesters must hold valid and payload stable until accepted. A valid that drops before the handshake is simply not granted, and the tie-break state is unchanged.
- A requester not granted keeps valid high and waits. Fairness: under continuous contention, grants strictly alternate.

## Timing
- Reset values: state=IDLE, res_valid=0, res_out=0, res_c_out=0, res_id=0, op_count=0, last=1.
- Both readies are 0 in reset; they may rise combinationally on valid after reset deasserts.
- Accept at edge k gives res_valid=1 after edge k+1, with outputs stable until consumption.
- Result consumed at edge m gives IDLE after m; the next accept is possible at edge m+1.
- Throughput: one op per 3 cycles with res_ready held high.
- HOLD with res_ready=0 holds indefinitely; no new request is accepted (both readies 0).
- Reset asserted in EXEC or HOLD aborts the op immediately: the pending result is discarded and op_count is not incremented.
- op_count increments only on the result handshake, never on request accept.

## Structure
- Shared package `alu_pkg`: op encodings (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11) and the state encoding (IDLE, EXEC, HOLD).
- One sub-module: a single instance of the existing `ALU`.
  - M_1/M_0 are driven from the latched op; c_in is tied to 0.
  - The ALU is not modified. Logic-op carry masking is done in this block.
- Arbiter, FSM, operand/result registers and counter live in `alu_arbiter`.

## Test plan
- Single add, requester 0: a=3'd5, b=3'd6. Expect res_out=3'd3, res_c_out=1, res_id=0, res_valid one edge after accept, op_count 0→1.
- Sub on requester 1: a=2, b=5 gives out=5, c_out=0. a=6, b=6 gives out=0, c_out=1.
- Contention, both valid continuously with res_ready=1, 6 ops:
  - Grant order is 0,1,0,1,0,1.
  - Each accept is 3 cycles apart.
  - The losing ready stays 0 while the other requester is served.
- Backpressure: res_ready=0 for 10 cycles in HOLD.
  - Result is stable.
  - Both readies are 0.
  - op_count is unchanged.
  - When res_ready rises, the result is consumed, and the next request is accepted one edge later.
- Logic ops: a=3'b110, b=3'b011. AND gives 3'b010, XOR gives 3'b101, res_c_out=0 both times, even directly after an add that produced carry 1.
- Reset mid-EXEC and mid-HOLD:
  - All outputs return to their reset values asynchronously.
  - The aborted op is not counted.
  - op_count wrap: 256 consumed ops returns op_count to 0.
